// File: rtl/sobel_window_gen.sv
// 3x3 raster-scan neighbourhood generator (centre omitted) for a Sobel stage.
// Optional frame_done_o pulse with the last window: define SOBEL_WIN_FRAME_DONE_EN.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pix_valid_i,
    output logic       pix_ready_o,
    input  logic [7:0] pix_data_i,
    input  logic       sof_i,
    output logic [7:0] p00_o,
    output logic [7:0] p01_o,
    output logic [7:0] p02_o,
    output logic [7:0] p10_o,
    output logic [7:0] p12_o,
    output logic [7:0] p20_o,
    output logic [7:0] p21_o,
    output logic [7:0] p22_o,
    output logic [9:0] win_x_o,
    output logic [9:0] win_y_o,
    output logic       win_valid_o,
    input  logic       win_ready_i,
`ifdef SOBEL_WIN_FRAME_DONE_EN
    output logic       frame_done_o,
`endif
    output logic [1:0] dbg_state_o
);

    // Handshake: a transfer happens on any cycle where valid && ready are both high;
    // valid never depends on ready, and a presented window holds until consumed.

    localparam int         CW       = $clog2(IMG_WIDTH);
    localparam logic [9:0] COL_LAST = 10'(IMG_WIDTH - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] col_q, row_q, col_d, row_d;
    logic [9:0] eff_col, eff_row;
    logic       accept, take, produce;
    logic [CW-1:0] lb_idx;
    logic [7:0] lb0_rd, lb1_rd;

    logic [7:0] lb0 [IMG_WIDTH];
    logic [7:0] lb1 [IMG_WIDTH];

    // Two oldest window columns; the newest column comes straight from the line buffers.
    logic [7:0] wa_top, wa_mid, wa_bot;
    logic [7:0] wb_top, wb_mid, wb_bot;

    assign pix_ready_o = !win_valid_o || win_ready_i;
    assign accept      = pix_valid_i && pix_ready_o;
    assign take        = accept && (sof_i || (state_q != IDLE));
    assign eff_col     = sof_i ? 10'd0 : col_q;
    assign eff_row     = sof_i ? 10'd0 : row_q;
    assign produce     = take && (eff_row >= 10'd2) && (eff_col >= 10'd2);
    assign lb_idx      = eff_col[CW-1:0];
    assign lb0_rd      = lb0[lb_idx];
    assign lb1_rd      = lb1[lb_idx];
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (take) begin
            if (eff_col == COL_LAST) begin
                col_d = 10'd0;
                row_d = (eff_row == ROW_LAST) ? 10'd0 : eff_row + 10'd1;
            end else begin
                col_d = eff_col + 10'd1;
                row_d = eff_row;
            end
            // Rows 0 and 1 only prime the line buffers; a wrap lands back in row 0.
            state_d = (row_d >= 10'd2) ? RUN : FILL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            col_q   <= 10'd0;
            row_q   <= 10'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (take) begin
            wa_top      <= wb_top;
            wa_mid      <= wb_mid;
            wa_bot      <= wb_bot;
            wb_top      <= lb1_rd;
            wb_mid      <= lb0_rd;
            wb_bot      <= pix_data_i;
            lb1[lb_idx] <= lb0_rd;
            lb0[lb_idx] <= pix_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_valid_o  <= 1'b0;
            p00_o        <= 8'd0;
            p01_o        <= 8'd0;
            p02_o        <= 8'd0;
            p10_o        <= 8'd0;
            p12_o        <= 8'd0;
            p20_o        <= 8'd0;
            p21_o        <= 8'd0;
            p22_o        <= 8'd0;
            win_x_o      <= 10'd0;
            win_y_o      <= 10'd0;
`ifdef SOBEL_WIN_FRAME_DONE_EN
            frame_done_o <= 1'b0;
`endif
        end else if (produce) begin
            win_valid_o  <= 1'b1;
            p00_o        <= wa_top;
            p10_o        <= wa_mid;
            p20_o        <= wa_bot;
            p01_o        <= wb_top;
            p21_o        <= wb_bot;
            p02_o        <= lb1_rd;
            p12_o        <= lb0_rd;
            p22_o        <= pix_data_i;
            win_x_o      <= eff_col - 10'd1;
            win_y_o      <= eff_row - 10'd1;
`ifdef SOBEL_WIN_FRAME_DONE_EN
            frame_done_o <= (eff_col == COL_LAST) && (eff_row == ROW_LAST);
`endif
        end else if (win_ready_i) begin
            win_valid_o  <= 1'b0;
`ifdef SOBEL_WIN_FRAME_DONE_EN
            frame_done_o <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x4 image: directed scenarios plus random traffic,
// scored against a frame-image model that cuts windows out of a 2-D pixel array.
module tb_sobel_window_gen;

    localparam int W = 4;
    localparam int H = 4;
`ifdef SOBEL_WIN_FRAME_DONE_EN
    localparam bit FD = 1'b1;
`else
    localparam bit FD = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] p00, p01, p02, p10, p12, p20, p21, p22;
        logic [9:0] x, y;
        logic       last;
    } win_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i = 1'b1;
    logic       pix_valid_i = 1'b0;
    logic       pix_ready_o;
    logic [7:0] pix_data_i = 8'd0;
    logic       sof_i = 1'b0;
    logic [7:0] p00_o, p01_o, p02_o, p10_o, p12_o, p20_o, p21_o, p22_o;
    logic [9:0] win_x_o, win_y_o;
    logic       win_valid_o;
    logic       win_ready_i = 1'b1;
    logic [1:0] dbg_state_o;
`ifdef SOBEL_WIN_FRAME_DONE_EN
    logic       frame_done_o;
`endif

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
        .pix_data_i(pix_data_i), .sof_i(sof_i),
        .p00_o(p00_o), .p01_o(p01_o), .p02_o(p02_o), .p10_o(p10_o),
        .p12_o(p12_o), .p20_o(p20_o), .p21_o(p21_o), .p22_o(p22_o),
        .win_x_o(win_x_o), .win_y_o(win_y_o),
        .win_valid_o(win_valid_o), .win_ready_i(win_ready_i),
`ifdef SOBEL_WIN_FRAME_DONE_EN
        .frame_done_o(frame_done_o),
`endif
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- model / scoreboard ----------------
    int   n_vec = 0;
    int   n_err = 0;
    win_t exp_q[$];
    win_t got_q[$];
    logic [7:0] img [H][W];
    int   pos = 0;
    bit   in_frame = 1'b0;
    bit   stall_prev = 1'b0;
    win_t cur, snap, cmp;

    function automatic win_t dut_win();
        win_t w;
        w.p00 = p00_o; w.p01 = p01_o; w.p02 = p02_o; w.p10 = p10_o;
        w.p12 = p12_o; w.p20 = p20_o; w.p21 = p21_o; w.p22 = p22_o;
        w.x = win_x_o; w.y = win_y_o;
`ifdef SOBEL_WIN_FRAME_DONE_EN
        w.last = frame_done_o;
`else
        w.last = 1'b0;
`endif
        return w;
    endfunction

    // Pixel stream as a picture: position = pos, row = pos / W, column = pos % W.
    task automatic model_accept(input logic [7:0] d, input logic s);
        int   r, c;
        win_t w;
        if (s) begin
            in_frame = 1'b1;
            pos = 0;
        end
        if (in_frame) begin
            r = pos / W;
            c = pos % W;
            img[r][c] = d;
            if (r >= 2 && c >= 2) begin
                w.p00 = img[r-2][c-2]; w.p01 = img[r-2][c-1]; w.p02 = img[r-2][c];
                w.p10 = img[r-1][c-2]; w.p12 = img[r-1][c];
                w.p20 = img[r][c-2];   w.p21 = img[r][c-1];   w.p22 = img[r][c];
                w.x = 10'(c - 1);
                w.y = 10'(r - 1);
                w.last = FD && (r == H - 1) && (c == W - 1);
                exp_q.push_back(w);
            end
            pos = (pos + 1) % (W * H);
        end
    endtask

    always @(negedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            in_frame = 1'b0;
            pos = 0;
            stall_prev = 1'b0;
        end else begin
            cur = dut_win();
            n_vec++;
            if (pix_ready_o !== (!win_valid_o || win_ready_i)) begin
                n_err++;
                $display("FAIL pix_ready: got %b required %b", pix_ready_o, !win_valid_o || win_ready_i);
            end
            if (stall_prev) begin
                n_vec++;
                if (win_valid_o !== 1'b1 || cur !== snap) begin
                    n_err++;
                    $display("FAIL hold_stable: got %h valid %b required %h valid 1", cur, win_valid_o, snap);
                end
            end
`ifdef SOBEL_WIN_FRAME_DONE_EN
            if (!win_valid_o && frame_done_o !== 1'b0) begin
                n_err++;
                $display("FAIL frame_done_idle: got %b required 0", frame_done_o);
            end
`endif
            if (win_valid_o && win_ready_i) begin
                got_q.push_back(cur);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_window: got %h required none", cur);
                end else begin
                    cmp = exp_q.pop_front();
                    if (cur !== cmp) begin
                        n_err++;
                        $display("FAIL window: got %h required %h", cur, cmp);
                    end
                end
            end
            if (pix_valid_i && pix_ready_o) model_accept(pix_data_i, sof_i);
            stall_prev = win_valid_o && !win_ready_i;
            snap = cur;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_pix(input logic [7:0] d, input logic s);
        bit acc = 1'b0;
        pix_valid_i = 1'b1;
        pix_data_i  = d;
        sof_i       = s;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = pix_ready_o;
            @(posedge clk);
            #1;
        end
        pix_valid_i = 1'b0;
        sof_i       = 1'b0;
        if (!acc) begin
            n_err++;
            $display("FAIL send_timeout: got no accept in 50 cycles required accept");
        end
    endtask

    task automatic idle(input int n);
        pix_valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit rnd);
        for (int i = 0; i < W * H; i++) send_pix(rnd ? 8'($urandom) : 8'(i), i == 0);
    endtask

    task automatic check_ref_frame(input string tag);
        win_t w;
        win_t ref0;
        ref0 = {8'd0, 8'd1, 8'd2, 8'd4, 8'd6, 8'd8, 8'd9, 8'd10, 10'd1, 10'd1, 1'b0};
        n_vec++;
        if (got_q.size() !== 4) begin
            n_err++;
            $display("FAIL %s_count: got %0d required 4", tag, got_q.size());
        end
        if (got_q.size() >= 4) begin
            w = got_q[0];
            w.last = 1'b0;
            n_vec++;
            if (w !== ref0) begin
                n_err++;
                $display("FAIL %s_first: got %h required %h", tag, w, ref0);
            end
            n_vec++;
            if (got_q[3].p22 !== 8'd15 || got_q[3].x !== 10'd2 || got_q[3].y !== 10'd2 || got_q[3].last !== FD) begin
                n_err++;
                $display("FAIL %s_last: got p22=%0d x=%0d y=%0d l=%b required 15 2 2 %b",
                         tag, got_q[3].p22, got_q[3].x, got_q[3].y, got_q[3].last, FD);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        pix_valid_i = 1'b1;
        sof_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (win_valid_o !== 1'b0 || dut_win() !== '0 || dbg_state_o !== 2'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b win=%h st=%0d required 0 0 0", win_valid_o, dut_win(), dbg_state_o);
        end
        rst_i = 1'b0;
        pix_valid_i = 1'b0;
        sof_i = 1'b0;
        n_vec++;
        if (pix_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b required 1", pix_ready_o);
        end
        idle(1);
    endtask

    task automatic test_frame();
        got_q.delete();
        win_ready_i = 1'b1;
        send_frame(1'b0);
        idle(4);
        check_ref_frame("frame");
    endtask

    task automatic test_backpressure();
        got_q.delete();
        fork
            send_frame(1'b0);
            begin
                bit seen = 1'b0;
                win_t hold;
                win_ready_i = 1'b0;
                for (int k = 0; k < 200 && !seen; k++) begin
                    @(negedge clk);
                    seen = win_valid_o;
                end
                n_vec++;
                if (!seen) begin
                    n_err++;
                    $display("FAIL bp_window_timeout: got no window required one");
                end
                hold = dut_win();
                for (int i = 0; i < 5; i++) begin
                    n_vec++;
                    if (pix_ready_o !== 1'b0 || win_valid_o !== 1'b1 || dut_win() !== hold) begin
                        n_err++;
                        $display("FAIL bp_stall: cycle %0d ready=%b valid=%b win=%h required 0 1 %h",
                                 i, pix_ready_o, win_valid_o, dut_win(), hold);
                    end
                    if (i < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                win_ready_i = 1'b1;
            end
        join
        idle(4);
        n_vec++;
        if (got_q.size() !== 4) begin
            n_err++;
            $display("FAIL bp_count: got %0d required 4", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            n_vec++;
            if (got_q[i].x !== 10'(1 + i % 2) || got_q[i].y !== 10'(1 + i / 2)) begin
                n_err++;
                $display("FAIL bp_order: idx %0d got x=%0d y=%0d required %0d %0d",
                         i, got_q[i].x, got_q[i].y, 1 + i % 2, 1 + i / 2);
            end
        end
    endtask

    task automatic test_idle_discard();
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        got_q.delete();
        for (int i = 0; i < 3; i++) send_pix(8'($urandom_range(100, 255)), 1'b0);
        n_vec++;
        if (dbg_state_o !== 2'd0) begin
            n_err++;
            $display("FAIL discard_state: got %0d required 0", dbg_state_o);
        end
        send_frame(1'b0);
        idle(4);
        check_ref_frame("discard");
    endtask

    task automatic test_resync();
        got_q.delete();
        for (int i = 0; i < 9; i++) send_pix(8'(i), i == 0);
        send_pix(8'($urandom), 1'b1);
        n_vec++;
        if (win_valid_o !== 1'b0 || dbg_state_o !== 2'd1) begin
            n_err++;
            $display("FAIL resync_state: got valid=%b st=%0d required 0 1", win_valid_o, dbg_state_o);
        end
        for (int i = 1; i < W * H; i++) send_pix(8'($urandom), 1'b0);
        idle(4);
        n_vec++;
        if (got_q.size() !== 4) begin
            n_err++;
            $display("FAIL resync_count: got %0d required 4", got_q.size());
        end else begin
            n_vec++;
            if (got_q[0].x !== 10'd1 || got_q[0].y !== 10'd1) begin
                n_err++;
                $display("FAIL resync_first: got x=%0d y=%0d required 1 1", got_q[0].x, got_q[0].y);
            end
        end
    endtask

    task automatic test_reset_mid();
        got_q.delete();
        win_ready_i = 1'b1;
        for (int i = 0; i < 14; i++) send_pix(8'(i), i == 0);
        win_ready_i = 1'b0;
        send_pix(8'd14, 1'b0);
        n_vec++;
        if (win_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pending: got %b required 1", win_valid_o);
        end
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        n_vec++;
        if (win_valid_o !== 1'b0 || dbg_state_o !== 2'd0) begin
            n_err++;
            $display("FAIL rstmid_cleared: got valid=%b st=%0d required 0 0", win_valid_o, dbg_state_o);
        end
        win_ready_i = 1'b1;
        got_q.delete();
        send_frame(1'b0);
        idle(4);
        check_ref_frame("rstmid");
    endtask

    task automatic test_back_to_back();
        int n_centre = 0;
        int n_done = 0;
        got_q.delete();
        win_ready_i = 1'b1;
        send_frame(1'b1);
        send_frame(1'b1);
        idle(4);
        foreach (got_q[i]) begin
            if (got_q[i].x == 10'd2 && got_q[i].y == 10'd2) n_centre++;
            if (got_q[i].last) n_done++;
            n_vec++;
            if (got_q[i].last !== (FD && got_q[i].x == 10'd2 && got_q[i].y == 10'd2)) begin
                n_err++;
                $display("FAIL b2b_done_place: idx %0d got %b required %b", i, got_q[i].last, !got_q[i].last);
            end
        end
        n_vec++;
        if (got_q.size() !== 8 || n_centre !== 2 || n_done !== (FD ? 2 : 0)) begin
            n_err++;
            $display("FAIL b2b_count: got n=%0d last_centres=%0d done=%0d required 8 2 %0d",
                     got_q.size(), n_centre, n_done, FD ? 2 : 0);
        end
    endtask

    task automatic test_random();
        got_q.delete();
        for (int n = 0; n < 1500; n++) begin
            pix_valid_i = ($urandom_range(0, 9) < 7);
            pix_data_i  = 8'($urandom);
            sof_i       = ($urandom_range(0, 99) < 3);
            win_ready_i = ($urandom_range(0, 9) < 6);
            @(posedge clk);
            #1;
        end
        sof_i = 1'b0;
        win_ready_i = 1'b1;
        idle(5);
        n_vec++;
        if (exp_q.size() !== 0 || got_q.size() == 0) begin
            n_err++;
            $display("FAIL random_drain: got pending=%0d seen=%0d required 0 and >0", exp_q.size(), got_q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_frame();
        test_backpressure();
        test_idle_discard();
        test_resync();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 64, pixels per line (legal range 3..1024).
REQ-002 SHALL have parameter IMG_HEIGHT, default 64, lines per frame (legal range 3..1024).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port pix_valid_i, input, 1, input pixel valid.
REQ-006 SHALL have port pix_ready_o, output, 1, input pixel ready.
REQ-007 SHALL have port pix_data_i, input, 8, grayscale pixel in raster order; bits pass through unchanged.
REQ-008 SHALL have port sof_i, input, 1, start of frame, qualified by pix_valid_i && pix_ready_o.
REQ-009 SHALL have ports p00_o, p01_o, p02_o, p10_o, p12_o, p20_o, p21_o, p22_o, output, 8 each, 3x3 neighbourhood without the centre; pRC_o is row R, column C.
REQ-010 SHALL have ports win_x_o and win_y_o, output, 10 each, centre column and centre row.
REQ-011 SHALL have port win_valid_o, output, 1, window valid.
REQ-012 SHALL have port win_ready_i, input, 1, downstream ready.

Function
REQ-013 A pixel SHALL be accepted on any cycle with pix_valid_i && pix_ready_o; a window SHALL be consumed on any cycle with win_valid_o && win_ready_i.
REQ-014 pix_ready_o SHALL equal !win_valid_o || win_ready_i (combinational; one output register stage, no skid).
REQ-015 The block SHALL hold two line buffers (LB0 = row r-1, LB1 = row r-2) of IMG_WIDTH x 8 bits, plus a 3x3 shift window.
REQ-016 On accepting pixel (r,c), the window SHALL shift left and load column {LB1[c], LB0[c], pix} as its right column; then LB1[c] <= LB0[c] and LB0[c] <= pix.
REQ-017 After accepting (r,c) with r>=2 and c>=2, the next cycle SHALL present p00=(r-2,c-2) through p22=(r,c), win_x_o=c-1, win_y_o=r-1, and win_valid_o=1; latency is 1 cycle.
REQ-018 No window SHALL be produced for c<2 or r<2; there is no border padding, so each frame yields (W-2)*(H-2) windows.
REQ-019 While win_valid_o && !win_ready_i, every window output SHALL hold stable.
REQ-020 If a window is consumed and no new window is loaded in the same cycle, win_valid_o SHALL fall the next cycle.
REQ-021 The FSM SHALL have states IDLE, FILL and RUN.
REQ-022 IDLE: pixels without sof_i are accepted and discarded; a pixel with sof_i becomes (0,0) and the FSM goes to FILL.
REQ-023 FILL (r<2): the FSM goes to RUN after accepting (1,W-1).
REQ-024 RUN: after accepting (H-1,W-1), counters SHALL wrap to (0,0) and the FSM goes to FILL.
REQ-025 Column counter SHALL wrap W-1 -> 0 and increment the row counter.
REQ-026 A pixel with sof_i accepted in FILL or RUN (mid-frame resync) SHALL be taken as (0,0), with the FSM going to FILL.
REQ-027 On a mid-frame resync, an already-registered window SHALL still be delivered.
REQ-028 A pixel with sof_i accepted on the cycle after (H-1,W-1) SHALL be treated identically to normal wrap.

Reset
REQ-029 While rst_i=1 at a clock edge, the FSM SHALL go to IDLE and counters to 0.
REQ-030 While rst_i=1 at a clock edge, win_valid_o, all pXX_o, win_x_o and win_y_o SHALL be 0.
REQ-031 Line-buffer contents need not be reset.
REQ-032 pix_ready_o SHALL be 1 in the first cycle after reset.
REQ-033 Reset mid-frame SHALL discard the pending window and any partial frame.

Configuration
REQ-034 Macro SOBEL_WIN_FRAME_DONE_EN defined: output frame_done_o (1 bit) SHALL pulse high for exactly 1 cycle, together with the last window of a frame, i.e. the window with centre (W-2,H-2).
REQ-035 With SOBEL_WIN_FRAME_DONE_EN defined, frame_done_o SHALL reset to 0.
REQ-036 With SOBEL_WIN_FRAME_DONE_EN defined, frame_done_o SHALL hold with the window under backpressure and clear when that window is consumed.
REQ-037 Macro SOBEL_WIN_FRAME_DONE_EN undefined: the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-038 W=H=4, pixel=r*4+c, sof on the first pixel, win_ready_i=1 -> 4 windows; the first has p00=0, p01=1, p02=2, p10=4, p12=6, p20=8, p21=9, p22=10, x=1, y=1; the last has p22=15, x=2, y=2.
REQ-039 Same stream, win_ready_i=0 for 5 cycles after the first window -> pix_ready_o=0 and outputs stable for those 5 cycles; no window is lost or duplicated.
REQ-040 After reset, 3 pixels without sof then a sof frame -> the 3 pixels are discarded; windows match REQ-038.
REQ-041 sof asserted at (2,1) of a W=H=4 frame -> the window of (2,0)... none pending; a new frame starts; windows from (2,2) onwards carry the new frame's coordinates starting at x=1, y=1.
REQ-042 rst_i pulsed at (3,2) -> win_valid_o=0 the next cycle; the next sof frame is correct.
REQ-043 With SOBEL_WIN_FRAME_DONE_EN, two back-to-back 4x4 frames -> exactly two frame_done_o pulses, each coincident with x=2, y=2.
